// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer feeding the 3x3 edge-detection datapath.
// Optional stall counter output enabled by defining SCAN_STALL_CNT_EN.
module window_scan_ctrl #(
   parameter int COL_BITS = 10,
   parameter int ROW_BITS = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [COL_BITS-1:0] img_width,
   input  logic [ROW_BITS-1:0] img_height,
   output logic                rd_req,
   input  logic                rd_ready,
   output logic [COL_BITS-1:0] rd_col,
   output logic [ROW_BITS-1:0] rd_row,
   output logic                win_valid,
   output logic [COL_BITS-1:0] win_col,
   output logic [ROW_BITS-1:0] win_row,
   output logic                busy,
   output logic                done,
   output logic                cfg_err
`ifdef SCAN_STALL_CNT_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FILL, SCAN, DONE} state_t;

   localparam logic [COL_BITS-1:0] MIN_COLS = COL_BITS'(3);
   localparam logic [ROW_BITS-1:0] MIN_ROWS = ROW_BITS'(3);
   localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
   localparam logic [COL_BITS-1:0] COL_TWO  = COL_BITS'(2);
   localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);

   state_t              state, next_state;
   logic [COL_BITS-1:0] width_q, col;
   logic [ROW_BITS-1:0] height_q, row;
   logic                scanning, cfg_ok, start_ok, accept, last_col, last_row;

   assign scanning = (state == FILL) || (state == SCAN);
   assign rd_req   = scanning;
   assign busy     = scanning;
   assign done     = (state == DONE);
   assign rd_col   = col;
   assign rd_row   = row;

   // Geometry is latched at start, so terminal compares never see width/height below 3
   // and width-1 / height-1 cannot wrap even at the maximum programmable size.
   assign cfg_ok   = (img_width >= MIN_COLS) && (img_height >= MIN_ROWS);
   assign start_ok = (state == IDLE) && start && cfg_ok;
   assign accept   = scanning && rd_ready && !abort;
   assign last_col = (col == width_q - COL_ONE);
   assign last_row = (row == height_q - ROW_ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start_ok) next_state = FILL;
         FILL: begin
            if (abort)                                     next_state = IDLE;
            else if (accept && last_col && row == ROW_ONE) next_state = SCAN;
         end
         SCAN: begin
            if (abort)                              next_state = IDLE;
            else if (accept && last_col && last_row) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Address counters plus the registered window pulse one cycle behind acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width_q   <= '0;
         height_q  <= '0;
         col       <= '0;
         row       <= '0;
         win_valid <= 1'b0;
         win_col   <= '0;
         win_row   <= '0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err   <= (state == IDLE) && start && !cfg_ok;
         win_valid <= (state == SCAN) && accept && (col >= COL_TWO);
         if ((state == SCAN) && accept && (col >= COL_TWO)) begin
            win_col <= col - COL_ONE;
            win_row <= row - ROW_ONE;
         end
         if (start_ok) begin
            width_q  <= img_width;
            height_q <= img_height;
            col      <= '0;
            row      <= '0;
         end else if (accept) begin
            if (last_col) begin
               col <= '0;
               row <= row + ROW_ONE;
            end else begin
               col <= col + COL_ONE;
            end
         end
      end
   end

`ifdef SCAN_STALL_CNT_EN
   // Counts cycles the frame buffer held off an outstanding request; saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                               stall_cnt <= '0;
      else if (start_ok)                                     stall_cnt <= '0;
      else if (rd_req && !rd_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl with a window scoreboard queue.
// Also checks stall_cnt when SCAN_STALL_CNT_EN is defined.
module tb_window_scan_ctrl;

   logic       clk, rst, start, abort, rd_ready;
   logic [9:0] img_width, img_height;
   logic       rd_req, win_valid, busy, done, cfg_err;
   logic [9:0] rd_col, rd_row, win_col, win_row;
`ifdef SCAN_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   typedef struct {
      int         due;
      logic [9:0] row;
      logic [9:0] col;
   } win_t;

   win_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   d, s;

   window_scan_ctrl #(.COL_BITS(10), .ROW_BITS(10)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .img_width(img_width), .img_height(img_height),
      .rd_req(rd_req), .rd_ready(rd_ready), .rd_col(rd_col), .rd_row(rd_row),
      .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
      .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef SCAN_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, observed, expected, cyc);
      end
   endtask

   // One clock: drive inputs, step past the edge, then settle the scoreboard for this cycle.
   task automatic applyStimulus(input logic s_in, input logic ab_in, input logic rdy_in,
                                input logic [9:0] w_in, input logic [9:0] h_in);
      start      = s_in;
      abort      = ab_in;
      rd_ready   = rdy_in;
      img_width  = w_in;
      img_height = h_in;
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         checkOutput("win_valid", 32'(win_valid), 32'd1);
         checkOutput("win_row", 32'(win_row), 32'(sb[0].row));
         checkOutput("win_col", 32'(win_col), 32'(sb[0].col));
         void'(sb.pop_front());
      end else begin
         checkOutput("win_valid_quiet", 32'(win_valid), 32'd0);
      end
   endtask

   task automatic runScan(input int w, input int h, input int stall_r, input int stall_c,
                          input int stall_n, input int abort_r, input int abort_c,
                          input bit hold_start, output int done_rel, output int stalls);
      int r, c, t0, guard;
      bit ab, rdy, fin;
      logic [9:0] wd, hd;
      t0       = cyc;
      done_rel = -1;
      applyStimulus(1'b1, 1'b0, 1'b0, 10'(w), 10'(h));
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      wd = hold_start ? 10'd1 : 10'(w);
      hd = hold_start ? 10'd1 : 10'(h);
      r = 0; c = 0; stalls = 0; guard = 0; fin = 0; ab = 0;
      while (!fin && guard < 20000) begin
         guard++;
         checkOutput("rd_req", 32'(rd_req), 32'd1);
         checkOutput("rd_row", 32'(rd_row), 32'(r));
         checkOutput("rd_col", 32'(rd_col), 32'(c));
         rdy = !(r == stall_r && c == stall_c && stalls < stall_n);
         if (!rdy) stalls++;
         ab = (r == abort_r && c == abort_c);
         if (rdy && !ab && r >= 2 && c >= 2) sb.push_back('{cyc + 1, 10'(r - 1), 10'(c - 1)});
         applyStimulus(hold_start, ab, rdy, wd, hd);
         if (ab) begin
            checkOutput("abort_rd_req", 32'(rd_req), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_done", 32'(done), 32'd0);
            fin = 1;
         end else if (rdy) begin
            if (c == w - 1) begin
               c = 0;
               r++;
            end else begin
               c++;
            end
            if (r == h) begin
               fin = 1;
               done_rel = cyc - t0;
               checkOutput("done_pulse", 32'(done), 32'd1);
               checkOutput("busy_at_done", 32'(busy), 32'd0);
               checkOutput("rd_req_at_done", 32'(rd_req), 32'd0);
`ifdef SCAN_STALL_CNT_EN
               checkOutput("stall_cnt_at_done", 32'(stall_cnt), 32'(stall_n));
`endif
            end
         end
      end
      checkOutput("scan_budget", 32'(guard < 20000), 32'd1);
      applyStimulus(hold_start, 1'b0, 1'b0, wd, hd);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("busy_after_scan", 32'(busy), 32'd0);
      checkOutput("rd_req_after_scan", 32'(rd_req), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
      img_width = '0; img_height = '0;
      #2;
      checkOutput("reset_rd_req", 32'(rd_req), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_cfg_err", 32'(cfg_err), 32'd0);
      checkOutput("reset_win_valid", 32'(win_valid), 32'd0);
      checkOutput("reset_addr", 32'({rd_row, rd_col}), 32'd0);
      checkOutput("reset_win_addr", 32'({win_row, win_col}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] basic 4x3 scan");
      runScan(4, 3, -1, -1, 0, -1, -1, 1'b0, d, s);
      checkOutput("done_cycle_basic", 32'(d), 32'd13);

      $display("[TB] 4x3 scan with 3-cycle stall at (1,3)");
      runScan(4, 3, 1, 3, 3, -1, -1, 1'b0, d, s);
      checkOutput("done_cycle_stall", 32'(d), 32'd16);
      checkOutput("stalls_applied", 32'(s), 32'd3);

      $display("[TB] undersized geometry");
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd2, 10'd5);
      checkOutput("cfg_err_narrow", 32'(cfg_err), 32'd1);
      checkOutput("cfg_err_rd_req", 32'(rd_req), 32'd0);
      checkOutput("cfg_err_busy", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd2, 10'd5);
      checkOutput("cfg_err_pulse_end", 32'(cfg_err), 32'd0);
      checkOutput("cfg_err_still_idle", 32'(busy), 32'd0);
      checkOutput("cfg_err_no_done", 32'(done), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd5, 10'd2);
      checkOutput("cfg_err_short", 32'(cfg_err), 32'd1);
      checkOutput("cfg_err_short_req", 32'(rd_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 10'd5, 10'd2);

      $display("[TB] abort at (3,2) then rescan");
      runScan(5, 5, -1, -1, 0, 3, 2, 1'b0, d, s);
      checkOutput("abort_never_done", 32'(d), 32'hFFFF_FFFF);
      applyStimulus(1'b0, 1'b1, 1'b1, 10'd5, 10'd5);
      checkOutput("abort_in_idle", 32'(busy), 32'd0);
      runScan(4, 3, -1, -1, 0, -1, -1, 1'b0, d, s);
      checkOutput("done_cycle_rescan", 32'(d), 32'd13);

      $display("[TB] asynchronous reset mid-scan");
      applyStimulus(1'b1, 1'b0, 1'b0, 10'd5, 10'd5);
      for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 1'b1, 10'd5, 10'd5);
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      checkOutput("pre_reset_addr", 32'({rd_row, rd_col}), 32'({10'd2, 10'd2}));
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_rd_req", 32'(rd_req), 32'd0);
      checkOutput("async_rst_busy", 32'(busy), 32'd0);
      checkOutput("async_rst_addr", 32'({rd_row, rd_col}), 32'd0);
`ifdef SCAN_STALL_CNT_EN
      checkOutput("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      checkOutput("start_in_reset_req", 32'(rd_req), 32'd0);
      checkOutput("start_in_reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      sb.delete();
      applyStimulus(1'b0, 1'b0, 1'b0, 10'd5, 10'd5);
      checkOutput("post_reset_idle", 32'(busy), 32'd0);

      $display("[TB] back-to-back scans with start held during the first");
      runScan(4, 3, -1, -1, 0, -1, -1, 1'b1, d, s);
      checkOutput("done_cycle_hold_start", 32'(d), 32'd13);
      runScan(5, 4, -1, -1, 0, -1, -1, 1'b0, d, s);
      checkOutput("done_cycle_5x4", 32'(d), 32'd21);

      $display("[TB] boundary geometries");
      runScan(3, 3, -1, -1, 0, -1, -1, 1'b0, d, s);
      checkOutput("done_cycle_3x3", 32'(d), 32'd10);
      runScan(1023, 3, -1, -1, 0, -1, -1, 1'b0, d, s);
      checkOutput("done_cycle_max_width", 32'(d), 32'd3070);
      runScan(3, 1023, -1, -1, 0, -1, -1, 1'b0, d, s);
      checkOutput("done_cycle_max_height", 32'(d), 32'd3070);

      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/window_scan_ctrl.md
Name: window_scan_ctrl

Overview:
- Raster-scan sequencer for the 3x3 edge-detection datapath.
- On `start`, walks an image of programmable width and height, one pixel per accepted read.
- Issues pixel read requests to the frame buffer with a req/ready handshake.
- Pulses `win_valid` with the window-centre coordinate once a full 3x3 neighbourhood is available to the convolution stage.

Parameters:
- COL_BITS, 10: width of column counter, `img_width` and column address outputs.
- ROW_BITS, 10: width of row counter, `img_height` and row address outputs.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a scan; honoured only in IDLE
- abort  in  1  synchronous cancel of a scan in progress
- img_width  in  COL_BITS  pixels per row, sampled on accepted start
- img_height  in  ROW_BITS  rows per image, sampled on accepted start
- rd_req  out  1  read request to frame buffer
- rd_ready  in  1  frame buffer accepts current request this cycle
- rd_col  out  COL_BITS  column of current request
- rd_row  out  ROW_BITS  row of current request
- win_valid  out  1  one-cycle pulse: 3x3 window complete
- win_col  out  COL_BITS  centre column of completed window
- win_row  out  ROW_BITS  centre row of completed window
- busy  out  1  high in FILL and SCAN
- done  out  1  one-cycle pulse at normal completion
- cfg_err  out  1  one-cycle pulse: start rejected, width or height < 3

Behaviour:
- Reset (rst high, asynchronous): state IDLE; all outputs and internal counters 0.
- States: IDLE, FILL, SCAN, DONE.
- IDLE, start=1, width and height both >= 3:
  - latch width and height; clear counters; next state FILL.
  - rd_req, busy high from the next cycle.
- IDLE, start=1, width or height < 3: cfg_err pulses next cycle; state stays IDLE.
- start outside IDLE is ignored.
- Handshake:
  - rd_req stays high with rd_row and rd_col stable until rd_req && rd_ready.
  - On acceptance, the address advances next cycle: col+1, or col=0 and row+1 when col == width-1.
  - No combinational path from rd_ready to rd_req.
- FILL: covers requests for rows 0 and 1. Moves to SCAN when (row 1, col width-1) is accepted.
- SCAN: covers rows 2..height-1.
  - Each acceptance at (r,c) with c >= 2 pulses win_valid one cycle later with win_row=r-1, win_col=c-1.
  - win_row and win_col hold their value between pulses.
- Last acceptance (height-1, width-1): next state DONE.
  - rd_req and busy drop in the following cycle.
  - done is high for exactly one cycle in DONE; then IDLE.
  - The final win_valid and done assert in the same cycle.
- abort = 1 in FILL or SCAN:
  - next cycle is IDLE with rd_req=0 and busy=0; no done.
  - a win_valid pending from the current cycle's acceptance is suppressed.
  - abort has priority over rd_ready in the same cycle.
- abort in IDLE or DONE has no effect.
- Back-to-back: start may be asserted in the cycle after done (IDLE).
- Widths: all counter arithmetic is unsigned at the declared widths. A maximum-valued width or height must not wrap the terminal compare.
- Reset mid-scan: immediate return to the reset state; in-flight request abandoned.

Optional Feature:
- Macro: SCAN_STALL_CNT_EN.
- Defined:
  - adds output `stall_cnt` [15:0], reset to 0 and cleared on accepted start.
  - increments each cycle with rd_req=1 and rd_ready=0; saturates at 16'hFFFF.
  - holds its value after done or abort.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Width 4, height 3, rd_ready tied 1, start at cycle 0:
  - reads accepted cycles 1..12 in raster order.
  - win_valid at cycles 12 and 13 with (row 1, col 1) and (row 1, col 2).
  - done high at cycle 13 only; busy low from cycle 14.
- Same image, rd_ready low for 3 cycles while at (1,3): rd_row=1 and rd_col=3 stay stable; done is delayed by exactly 3 cycles. With SCAN_STALL_CNT_EN defined, stall_cnt=3 at done.
- Width 2, height 5, start: cfg_err pulses one cycle; rd_req, busy and done stay 0.
- Width 5, height 5, abort asserted while rd_req is at (3,2) with rd_ready=1: no win_valid for that acceptance; IDLE and rd_req=0 next cycle; done never asserts. A following start rescans from (0,0).
- rst asserted asynchronously mid-SCAN (between clock edges): outputs go to 0 immediately; start ignored while rst is high.
- done followed by start in the next cycle: the second scan begins correctly; width/height changed between scans are honoured.
